// File: rtl/counter2bit_sched.sv
`default_nettype none
// ============================================================================
// Module   : counter2bit_sched
// Brief    : Round-robin scheduler sharing one 2-bit up/down counter between
//            two requesters, with a shadow count and sticky mismatch check.
// Revision : 1.0 - initial release
// ============================================================================
module counter2bit_sched #(
    parameter int LEN_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_dir,
    input  logic [2*LEN_W-1:0] req_len,
    output logic               cnt_en,
    output logic               cnt_up_down,
    input  logic [1:0]         cnt_count,
    output logic               busy,
    output logic               wrap,
    output logic               done,
    output logic               done_id,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_id;
    logic             r_id;
    logic             r_dir;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_shadow;
    logic             r_err;
    logic             w_win_id;
    logic             w_accept;
    logic [LEN_W-1:0] w_win_len;

    // Contention goes to the requester not served last; r_last_id resets to 1
    // so req0 wins the first tie.
    always_comb begin
        w_win_id = 1'b0;
        unique case (req_valid)
            2'b01:   w_win_id = 1'b0;
            2'b10:   w_win_id = 1'b1;
            2'b11:   w_win_id = ~r_last_id;
            default: w_win_id = 1'b0;
        endcase
        w_accept  = (r_state == ST_IDLE) && (req_valid != 2'b00);
        w_win_len = w_win_id ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    end

    always_comb begin
        req_ready   = w_accept ? (w_win_id ? 2'b10 : 2'b01) : 2'b00;
        cnt_en      = (r_state == ST_RUN);
        cnt_up_down = (r_state == ST_RUN) && r_dir;
        wrap        = (r_state == ST_RUN) &&
                      (r_dir ? (r_shadow == 2'd3) : (r_shadow == 2'd0));
        done        = (r_state == ST_DONE);
        done_id     = (r_state == ST_DONE) && r_id;
        busy        = (r_state != ST_IDLE);
        err         = r_err;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_win_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_remaining == LEN_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last_id   <= 1'b1;
            r_id        <= 1'b0;
            r_dir       <= 1'b0;
            r_remaining <= '0;
            r_shadow    <= 2'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_id        <= w_win_id;
                r_last_id   <= w_win_id;
                r_dir       <= req_dir[w_win_id];
                r_remaining <= w_win_len;
            end
            if (r_state == ST_RUN) begin
                r_shadow    <= r_dir ? r_shadow + 2'd1 : r_shadow - 2'd1;
                r_remaining <= r_remaining - LEN_W'(1);
            end
            // Counter and shadow step on the same edge, so compare current values.
            if ((r_state != ST_IDLE) && (cnt_count != r_shadow)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter2bit_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter2bit_sched
// Brief    : Directed self-checking bench for counter2bit_sched with a
//            behavioural 2-bit counter attached to the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter2bit_sched;

    localparam int c_len_w = 4;

    logic               clk;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_dir;
    logic [2*c_len_w-1:0] req_len;
    logic               cnt_en;
    logic               cnt_up_down;
    logic [1:0]         cnt_count;
    logic               busy;
    logic               wrap;
    logic               done;
    logic               done_id;
    logic               err;

    logic [1:0]         r_cnt;
    logic [1:0]         corrupt;

    int n_checks = 0;
    int n_pass   = 0;
    int en_cnt   = 0;
    int wrap_cnt = 0;
    int q_done[$];
    int q_grant[$];

    counter2bit_sched #(.LEN_W(c_len_w)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dir     (req_dir),
        .req_len     (req_len),
        .cnt_en      (cnt_en),
        .cnt_up_down (cnt_up_down),
        .cnt_count   (cnt_count),
        .busy        (busy),
        .wrap        (wrap),
        .done        (done),
        .done_id     (done_id),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter under control, sharing the scheduler reset.
    always @(posedge clk) begin
        if (!reset)      r_cnt <= 2'd0;
        else if (cnt_en) r_cnt <= cnt_up_down ? r_cnt + 2'd1 : r_cnt - 2'd1;
    end
    assign cnt_count = r_cnt ^ corrupt;

    always @(negedge clk) begin
        if (reset) begin
            en_cnt   = en_cnt + (cnt_en ? 1 : 0);
            wrap_cnt = wrap_cnt + (wrap ? 1 : 0);
            if (done) q_done.push_back(int'(done_id));
            if ((req_valid & req_ready) != 2'b00) q_grant.push_back(req_ready[1] ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        en_cnt   = 0;
        wrap_cnt = 0;
        q_done.delete();
        q_grant.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Drops each requester's valid once granted; returns when idle with nothing pending.
    task automatic run_until_idle(input string tag, input int max_cyc);
        logic [1:0] g;
        bit         ok;
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            #1;
            g = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~g;
            if (!busy && req_valid == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 2'b00;
        req_dir   = 2'b00;
        req_len   = '0;
        corrupt   = 2'b00;
        tick();
        tick();
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_en",    32'(cnt_en),    32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_wrap",  32'(wrap),      32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_count", 32'(cnt_count), 32'd0);
        reset = 1'b1;
        tick();

        // 1: req0 up len=5
        clear_mon();
        req_valid = 2'b01;
        req_dir   = 2'b01;
        req_len   = {4'd0, 4'd5};
        #1;
        check("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("t1_en%0d", i),   32'(cnt_en),      32'd1);
            check($sformatf("t1_dir%0d", i),  32'(cnt_up_down), 32'd1);
            check($sformatf("t1_wrap%0d", i), 32'(wrap),        32'(i == 4));
            tick();
        end
        check("t1_done",    32'(done),      32'd1);
        check("t1_done_id", 32'(done_id),   32'd0);
        check("t1_en_off",  32'(cnt_en),    32'd0);
        check("t1_count",   32'(cnt_count), 32'd1);
        check("t1_err",     32'(err),       32'd0);
        tick();
        check("t1_idle",    32'(busy),      32'd0);
        check("t1_done_lo", 32'(done),      32'd0);

        // 2: both valid from reset, req0 up 2 then req1 down 3
        do_reset();
        clear_mon();
        req_valid = 2'b11;
        req_dir   = 2'b01;
        req_len   = {4'd3, 4'd2};
        run_until_idle("t2", 40);
        check("t2_ndone", 32'(q_done.size()), 32'd2);
        if (q_done.size() == 2) begin
            check("t2_id0", 32'(q_done[0]), 32'd0);
            check("t2_id1", 32'(q_done[1]), 32'd1);
        end
        check("t2_count", 32'(cnt_count), 32'd3);
        check("t2_wraps", 32'(wrap_cnt),  32'd1);
        check("t2_steps", 32'(en_cnt),    32'd5);

        // 3: both continuously valid, len=1 each: strict alternation
        clear_mon();
        req_valid = 2'b11;
        req_dir   = 2'b01;
        req_len   = {4'd1, 4'd1};
        repeat (12) tick();
        req_valid = 2'b00;
        run_until_idle("t3", 10);
        check("t3_ngrant", 32'(q_grant.size()), 32'd4);
        if (q_grant.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_grant%0d", i), 32'(q_grant[i]), 32'(i % 2));
        end
        check("t3_ndone", 32'(q_done.size()), 32'd4);
        check("t3_steps", 32'(en_cnt),        32'd4);
        check("t3_wraps", 32'(wrap_cnt),      32'd4);
        check("t3_count", 32'(cnt_count),     32'd3);

        // 4: req1 len=0
        clear_mon();
        req_valid = 2'b10;
        req_dir   = 2'b10;
        req_len   = {4'd0, 4'd0};
        #1;
        check("t4_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        check("t4_done",    32'(done),    32'd1);
        check("t4_done_id", 32'(done_id), 32'd1);
        check("t4_en",      32'(cnt_en),  32'd0);
        check("t4_busy",    32'(busy),    32'd1);
        tick();
        check("t4_idle",  32'(busy),      32'd0);
        check("t4_steps", 32'(en_cnt),    32'd0);
        check("t4_count", 32'(cnt_count), 32'd3);

        // 5: corrupted counter readback mid-RUN
        clear_mon();
        req_valid = 2'b01;
        req_dir   = 2'b01;
        req_len   = {4'd0, 4'd4};
        tick();
        req_valid = 2'b00;
        check("t5_err_pre", 32'(err), 32'd0);
        corrupt = 2'b01;
        tick();
        corrupt = 2'b00;
        check("t5_err_set", 32'(err), 32'd1);
        run_until_idle("t5", 10);
        check("t5_ndone",    32'(q_done.size()), 32'd1);
        check("t5_err_hold", 32'(err),           32'd1);
        tick();
        check("t5_err_sticky", 32'(err), 32'd1);
        do_reset();
        check("t5_err_clr", 32'(err), 32'd0);

        // 6: reset in 3rd RUN cycle of len=8
        clear_mon();
        req_valid = 2'b01;
        req_dir   = 2'b01;
        req_len   = {4'd0, 4'd8};
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check("t6_running", 32'(cnt_en), 32'd1);
        reset = 1'b0;
        tick();
        check("t6_busy",  32'(busy),      32'd0);
        check("t6_en",    32'(cnt_en),    32'd0);
        check("t6_done",  32'(done),      32'd0);
        check("t6_err",   32'(err),       32'd0);
        check("t6_count", 32'(cnt_count), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("t6_no_done", 32'(q_done.size()), 32'd0);
        req_valid = 2'b01;
        req_len   = {4'd0, 4'd1};
        #1;
        check("t6_ready", 32'(req_ready), 32'd1);
        run_until_idle("t6", 10);
        check("t6_ndone", 32'(q_done.size()), 32'd1);
        check("t6_count2", 32'(cnt_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
